// File: rtl/pc_fetch.sv
// pc_fetch: fetch stage of the single-cycle MIPS core.
// Owns the PC and computes next-PC from seq/branch/jump/jr requests.
// Runs a RUN/STALL/HALT machine that stops on a NOP run or bad PC.
// Ports:
//   clk, rst          - clock, async active-high reset
//   en                - fetch enable (0 = stall)
//   instr_in          - ROM word at addr
//   branch_taken/imm  - taken branch and its raw offset field
//   jump/jump_idx     - J/JAL and its index field
//   jr/jr_addr        - JR and its register target
//   addr, pc_plus4    - current PC and PC+4
//   instr_out         - instruction to decode (0 when not valid)
//   instr_valid       - high only in RUN
//   halted            - high in HALT
//   misaligned        - sticky flag for a JR to a non-word address
module pc_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64,
    parameter int          HALT_NOPS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] instr_in,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_idx,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] addr,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        halted,
    output logic        misaligned
);

    localparam int NW = $clog2(HALT_NOPS + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [31:0]   pc, pc_nx;
    logic [NW-1:0] nop_cnt, nop_nx;
    logic          mis, mis_nx;
    logic          out_of_range;
    logic          last_nop;
    logic [31:0]   br_off;

    assign addr        = pc;
    assign pc_plus4    = pc + 32'd4;
    assign instr_valid = (state == RUN);
    assign halted      = (state == HALT);
    assign instr_out   = instr_valid ? instr_in : 32'd0;
    assign misaligned  = mis;

    assign out_of_range = 32'(pc[31:2]) >= 32'(MEM_WORDS);
    // this NOP would complete the run of HALT_NOPS
    assign last_nop     = (nop_cnt == NW'(HALT_NOPS - 1));
    assign br_off       = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pc      <= RESET_PC;
            nop_cnt <= '0;
            mis     <= 1'b0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            nop_cnt <= nop_nx;
            mis     <= mis_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        nop_nx   = nop_cnt;
        mis_nx   = mis;
        unique case (state)
            RUN: begin
                // range halt outranks en and all requests
                if (out_of_range) begin
                    state_nx = HALT;
                end else if (!en) begin
                    state_nx = STALL;
                end else if (jr) begin
                    pc_nx  = {jr_addr[31:2], 2'b00};
                    nop_nx = '0;
                    if (jr_addr[1:0] != 2'b00) mis_nx = 1'b1;
                end else if (jump) begin
                    pc_nx  = {pc_plus4[31:28], jump_idx, 2'b00};
                    nop_nx = '0;
                end else if (branch_taken) begin
                    pc_nx  = pc_plus4 + br_off;
                    nop_nx = '0;
                end else if (instr_in != 32'd0) begin
                    pc_nx  = pc_plus4;
                    nop_nx = '0;
                end else if (last_nop) begin
                    state_nx = HALT;
                end else begin
                    pc_nx  = pc_plus4;
                    nop_nx = nop_cnt + NW'(1);
                end
            end
            STALL: begin
                // resume without advancing PC on this edge
                if (en) state_nx = RUN;
            end
            HALT: begin
                state_nx = HALT;
            end
            default: begin
                state_nx = HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized + directed bench for pc_fetch.
// A behavioural fetch model predicts every output each cycle.
module tb_pc_fetch;

    localparam int MEM_WORDS = 16;
    localparam int HALT_NOPS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic [31:0] instr_in;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_idx = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = '0;
    logic [31:0] addr, pc_plus4, instr_out;
    logic        instr_valid, halted, misaligned;

    logic [31:0] rom [64];

    int total = 0;
    int bad = 0;

    // model state
    logic [31:0] m_pc;
    bit          m_halt, m_stall, m_mis;
    int          m_nops;

    pc_fetch #(
        .RESET_PC (32'h0),
        .MEM_WORDS(MEM_WORDS),
        .HALT_NOPS(HALT_NOPS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .instr_in    (instr_in),
        .branch_taken(branch_taken),
        .branch_imm  (branch_imm),
        .jump        (jump),
        .jump_idx    (jump_idx),
        .jr          (jr),
        .jr_addr     (jr_addr),
        .addr        (addr),
        .pc_plus4    (pc_plus4),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .halted      (halted),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_at(input logic [31:0] a);
        if (a[31:8] == 24'd0) return rom[a[7:2]];
        return 32'hFFFF_FFFF;
    endfunction

    always_comb instr_in = rom_at(addr);

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_pc    = 32'h0;
        m_halt  = 0;
        m_stall = 0;
        m_mis   = 0;
        m_nops  = 0;
    endtask

    // one clock edge worth of fetch behaviour, from current inputs
    task automatic m_step();
        logic [31:0] ins, p4;
        logic signed [31:0] off;
        if (m_halt) return;
        if (m_stall) begin
            if (en) m_stall = 0;
            return;
        end
        if (m_pc / 4 >= MEM_WORDS) begin
            m_halt = 1;
            return;
        end
        if (!en) begin
            m_stall = 1;
            return;
        end
        ins = rom_at(m_pc);
        p4  = m_pc + 4;
        if (jr) begin
            m_pc = jr_addr & ~32'd3;
            if (jr_addr % 4 != 0) m_mis = 1;
            m_nops = 0;
        end else if (jump) begin
            m_pc = (p4 & 32'hF000_0000) + 32'(jump_idx) * 4;
            m_nops = 0;
        end else if (branch_taken) begin
            off  = 32'($signed(branch_imm));
            m_pc = p4 + off * 4;
            m_nops = 0;
        end else if (ins != 0) begin
            m_pc = p4;
            m_nops = 0;
        end else if (m_nops + 1 == HALT_NOPS) begin
            m_halt = 1;
        end else begin
            m_pc = p4;
            m_nops++;
        end
    endtask

    task automatic check_all(input string tag);
        bit v;
        v = !m_halt && !m_stall;
        chk({tag, ".addr"}, addr, m_pc);
        chk({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
        chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
        chk({tag, ".iout"}, instr_out, v ? rom_at(m_pc) : 32'd0);
        chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
        chk({tag, ".mis"}, 32'(misaligned), 32'(m_mis));
    endtask

    task automatic clr_ctl();
        en = 1'b1;
        branch_taken = 1'b0;
        branch_imm = '0;
        jump = 1'b0;
        jump_idx = '0;
        jr = 1'b0;
        jr_addr = '0;
    endtask

    // called at a negedge with inputs set
    task automatic cycle(input string tag);
        m_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    // reset asserted mid-cycle, checked before any clock edge
    task automatic do_reset();
        @(negedge clk);
        clr_ctl();
        #2 rst = 1'b1;
        m_reset();
        #1 check_all("rst_async");
        @(posedge clk);
        #1 check_all("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        #1 check_all("rst_rel");
    endtask

    task automatic load_prog();
        foreach (rom[i]) rom[i] = 32'd0;
        rom[0] = 32'h2008_0005;
        rom[1] = 32'h2009_000A;
        rom[2] = 32'h0109_5020;
    endtask

    initial begin
        load_prog();
        clr_ctl();

        // program run to NOP halt
        do_reset();
        chk("reset_addr", addr, 32'h0);
        chk("reset_pc4", pc_plus4, 32'h4);
        for (int i = 0; i < 7; i++) cycle("prog");
        chk("prog_halt_addr", addr, 32'd24);
        chk("prog_halted", 32'(halted), 32'd1);
        chk("prog_valid", 32'(instr_valid), 32'd0);
        cycle("prog_hold");
        chk("prog_hold_addr", addr, 32'd24);

        // reset while halted, then resume
        do_reset();
        chk("rst_halt_addr", addr, 32'h0);
        chk("rst_halt_h", 32'(halted), 32'd0);
        cycle("resume");
        chk("resume_addr", addr, 32'd4);

        // branch back from PC=8
        cycle("br_pre");
        branch_taken = 1'b1;
        branch_imm = 16'hFFFE;
        cycle("br");
        chk("br_addr", addr, 32'd4);
        clr_ctl();
        cycle("br_post");

        // jump to word 16, out of range
        do_reset();
        cycle("j_pre");
        jump = 1'b1;
        jump_idx = 26'h10;
        cycle("j");
        chk("j_addr", addr, 32'h40);
        clr_ctl();
        cycle("j_range");
        chk("j_halted", 32'(halted), 32'd1);
        chk("j_hold", addr, 32'h40);

        // jr beats jump, misaligned sticks
        do_reset();
        jr = 1'b1;
        jump = 1'b1;
        jump_idx = 26'h5;
        jr_addr = 32'h0000_000E;
        cycle("jr");
        chk("jr_addr", addr, 32'h0C);
        chk("jr_mis", 32'(misaligned), 32'd1);
        clr_ctl();
        for (int i = 0; i < 3; i++) cycle("jr_post");
        chk("jr_mis_sticky", 32'(misaligned), 32'd1);

        // stall at PC=8
        do_reset();
        cycle("st_a");
        cycle("st_b");
        en = 1'b0;
        for (int i = 0; i < 3; i++) cycle("stall");
        chk("stall_addr", addr, 32'd8);
        chk("stall_iout", instr_out, 32'd0);
        en = 1'b1;
        cycle("st_resume");
        chk("st_resume_addr", addr, 32'd8);
        cycle("st_next");
        chk("st_next_addr", addr, 32'd12);

        // random
        for (int n = 0; n < 600; n++) begin
            if (m_halt || $urandom_range(0, 80) == 0) begin
                foreach (rom[i])
                    rom[i] = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
                do_reset();
            end else begin
                en = ($urandom_range(0, 4) != 0);
                jr = ($urandom_range(0, 12) == 0);
                jr_addr = 32'($urandom_range(0, 72));
                jump = ($urandom_range(0, 12) == 0);
                jump_idx = 26'($urandom_range(0, 20));
                branch_taken = ($urandom_range(0, 8) == 0);
                branch_imm = 16'($signed($urandom_range(0, 16)) - 8);
                cycle("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
